// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//
// Bundles the instruction fields, memory handshakes and datapath control
// strobes exchanged between the multi-cycle control unit and its
// environment (instruction register, ALU, memories, PC logic).
//
// Signals:
//   cond, tipo, opcode, flag_mov_shift  latched instruction fields
//   alu_flags                           {N,Z,C,V} of the current ALU result
//   imem_valid, dmem_ready              memory handshakes
//   IRWrite, PCWrite, Branch, RegWrite,
//   MemWrite, MemRead, ResultSrc,
//   ALUSrc, ImmSrc, ALUControl          datapath controls
//   flags_q, fault, state_q             architectural flags, sticky fault,
//                                       debug state
//
// Modports:
//   slave  - the control unit (consumes fields/handshakes, drives controls)
//   master - the environment / datapath side
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int FLAGS_W  = 4
) ();

  logic [1:0]          cond;
  logic [1:0]          tipo;
  logic [OPCODE_W-1:0] opcode;
  logic [1:0]          flag_mov_shift;
  logic [FLAGS_W-1:0]  alu_flags;
  logic                imem_valid;
  logic                dmem_ready;

  logic                IRWrite;
  logic                PCWrite;
  logic                Branch;
  logic                RegWrite;
  logic                MemWrite;
  logic                MemRead;
  logic                ResultSrc;
  logic                ALUSrc;
  logic [1:0]          ImmSrc;
  logic [OPCODE_W-1:0] ALUControl;
  logic [FLAGS_W-1:0]  flags_q;
  logic                fault;
  logic [2:0]          state_q;

  modport slave (
    input  cond, tipo, opcode, flag_mov_shift, alu_flags,
           imem_valid, dmem_ready,
    output IRWrite, PCWrite, Branch, RegWrite, MemWrite, MemRead,
           ResultSrc, ALUSrc, ImmSrc, ALUControl, flags_q, fault, state_q
  );

  modport master (
    output cond, tipo, opcode, flag_mov_shift, alu_flags,
           imem_valid, dmem_ready,
    input  IRWrite, PCWrite, Branch, RegWrite, MemWrite, MemRead,
           ResultSrc, ALUSrc, ImmSrc, ALUControl, flags_q, fault, state_q
  );

endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle control sequencer for the RIDA CPU. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH. The unit owns the NZCV
// flag register, evaluates the 2-bit condition field in DECODE and stalls
// on the instruction- and data-memory handshakes. A data access that waits
// MEM_TIMEOUT cycles without dmem_ready raises a sticky fault and parks the
// unit in HALT until reset.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   bus   - multicycle_control_unit_if.slave: instruction fields, memory
//           handshakes, datapath strobes, flags_q, fault, state_q
//
// All datapath strobes are combinational on state_q and the latched
// instruction fields; they are forced low while rst is asserted so a reset
// in the middle of a memory access withdraws the strobe immediately.
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W    = 3,
  parameter int FLAGS_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] TIPO_REG  = 2'b00;
  localparam logic [1:0] TIPO_IMM  = 2'b01;
  localparam logic [1:0] TIPO_MEM  = 2'b10;
  localparam logic [1:0] TIPO_CTRL = 2'b11;

  // Counter wide enough to hold MEM_TIMEOUT; one extra bit on the
  // incremented value keeps the terminal compare free of wrap-around.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(MEM_TIMEOUT);

  // Flag bit positions inside {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 0;

  state_e              state_q, state_d;
  logic [FLAGS_W-1:0]  flags_q, flags_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [CNT_W:0]      cnt_inc;
  logic                timeout_hit;
  logic                cond_ok;
  logic                is_store;
  logic [OPCODE_W-1:0] op_ctrl;

  logic                ir_write;
  logic                pc_write;
  logic                branch;
  logic                reg_write;
  logic                mem_write;
  logic                mem_read;
  logic                result_src;
  logic                alu_src;
  logic [1:0]          imm_src;
  logic [OPCODE_W-1:0] alu_ctrl;

  // -------------------------------------------------------------------------
  // State, flag, fault and wait-counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      flags_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Field decode helpers
  // -------------------------------------------------------------------------
  always_comb begin
    cond_ok = 1'b1;
    case (bus.cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = flags_q[FLAG_Z];
      2'b10:   cond_ok = ~flags_q[FLAG_Z];
      default: cond_ok = flags_q[FLAG_N] ^ flags_q[FLAG_V];
    endcase
  end

  // MOV (opcode all-ones) with a non-zero shift mode selects one of the
  // shifter operations {1, mode}; otherwise the opcode is the ALU op.
  always_comb begin
    op_ctrl = bus.opcode;
    if ((bus.opcode == {OPCODE_W{1'b1}}) && (bus.flag_mov_shift != 2'b00)) begin
      op_ctrl = OPCODE_W'({1'b1, bus.flag_mov_shift});
    end
  end

  assign is_store = bus.opcode[0];
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // The cycle whose stall would bring the counter to MEM_TIMEOUT is the
  // last cycle the access may still complete; a ready in that cycle wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !bus.dmem_ready &&
                       (cnt_inc == TIMEOUT_V);

  // -------------------------------------------------------------------------
  // Next-state and strobe logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    fault_d    = fault_q;
    cnt_d      = '0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    result_src = 1'b0;
    alu_src    = 1'b0;
    imm_src    = 2'b00;
    alu_ctrl   = '0;

    case (state_q)
      S_FETCH: begin
        if (bus.imem_valid) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cond_ok) begin
          state_d = S_EXEC;
        end else begin
          // Squash: skip the instruction, advance PC, leave flags alone.
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src = (bus.tipo != TIPO_REG);
        imm_src = (bus.tipo == TIPO_REG) ? 2'b00 : bus.tipo;
        case (bus.tipo)
          TIPO_REG, TIPO_IMM: begin
            alu_ctrl = op_ctrl;
            flags_d  = bus.alu_flags;
            state_d  = S_WB;
          end
          TIPO_MEM: begin
            alu_ctrl = '0;
            state_d  = S_MEM;
          end
          TIPO_CTRL: begin
            if (bus.opcode == {OPCODE_W{1'b1}}) begin
              state_d = S_HALT;
            end else begin
              branch   = 1'b1;
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_read  = ~is_store;
        mem_write = is_store;
        if (bus.dmem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        result_src = (bus.tipo == TIPO_MEM);
        state_d    = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset withdraws every strobe at once, even mid-access.
    if (rst) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      result_src = 1'b0;
      alu_src    = 1'b0;
      imm_src    = 2'b00;
      alu_ctrl   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.Branch     = branch;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.MemRead    = mem_read;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrc     = alu_src;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_ctrl;
  assign bus.flags_q    = flags_q;
  assign bus.fault      = fault_q;
  assign bus.state_q    = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle control decoder of the RIDA CPU. Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. Holds an internal NZCV flag register and evaluates the 2-bit condition field. Drives one-hot-in-time datapath enables, and stalls on instruction-memory and data-memory handshakes.

Parameters:
OPCODE_W, 3, opcode field width; ALU_CTRL_W == OPCODE_W.
FLAGS_W, 4, ALU flag vector width, ordered {N,Z,C,V}; must be 4.
MEM_TIMEOUT, 15, max DMEM wait cycles before fault; 0 disables timeout.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cond  in  2  condition field of latched instruction.
tipo  in  2  00 REG, 01 IMM, 10 MEM, 11 CTRL.
opcode  in  OPCODE_W  opcode field.
flag_mov_shift  in  2  MOV shift mode; 00 = plain MOV.
alu_flags  in  FLAGS_W  ALU flags of the current EXECUTE result.
imem_valid  in  1  instruction word available.
dmem_ready  in  1  data memory access complete.
IRWrite  out  1  latch instruction register.
PCWrite  out  1  PC <= PC+1 or branch target.
Branch  out  1  select branch target for PCWrite.
RegWrite  out  1  register-file write enable.
MemWrite  out  1  data-memory write strobe.
MemRead  out  1  data-memory read strobe.
ResultSrc  out  1  0 = ALU result, 1 = memory data.
ALUSrc  out  1  0 = register, 1 = immediate.
ImmSrc  out  2  equals tipo when tipo != REG, else 00.
ALUControl  out  ALU_CTRL_W  ALU operation.
flags_q  out  FLAGS_W  architectural flag register.
fault  out  1  sticky DMEM timeout fault.
state_q  out  3  current state for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset: asynchronous. State = FETCH, flags_q = 0, fault = 0, wait counter = 0, all strobes 0, ALUControl = 0, ImmSrc = 0.
- Reset mid-access drops all strobes immediately.
- Strobes are combinational on state_q and the latched fields. Each strobe is high for exactly the cycles listed below.
- FETCH: waits for imem_valid.
  - IRWrite=1 only in the cycle imem_valid=1. Next state is DECODE.
- DECODE (1 cycle): evaluates the condition against flags_q.
  - 00 always, 01 EQ (Z), 10 NE (!Z), 11 LT (N^V).
  - Condition false: PCWrite=1, Branch=0, next state FETCH. The instruction is squashed and flags are unchanged.
  - Condition true: next state EXEC.
- EXEC:
  - ALUSrc = (tipo != REG).
  - ALUControl = opcode for REG/IMM.
  - When opcode == all-ones (MOV) and flag_mov_shift != 00: ALUControl = {1'b1, flag_mov_shift} zero-extended to width.
  - ALUControl = 0 (ADD) for MEM address generation.
  - REG/IMM: flags_q <= alu_flags at the end of EXEC, next state WB.
  - MEM: next state MEM.
  - CTRL: Branch=1 and PCWrite=1, next state FETCH; flags unchanged.
  - CTRL with opcode all-ones: next state HALT, no PCWrite.
- MEM:
  - opcode[0]=0 is a load: MemRead=1. opcode[0]=1 is a store: MemWrite=1.
  - Strobe holds until dmem_ready=1, inclusive of that cycle.
  - Load with dmem_ready: next state WB.
  - Store with dmem_ready: PCWrite=1 in the same cycle, next state FETCH.
  - Wait counter increments on each cycle with dmem_ready=0. If it reaches MEM_TIMEOUT: fault <= 1, strobe drops, next state HALT.
- WB (1 cycle): RegWrite=1, PCWrite=1, next state FETCH.
  - ResultSrc = 1 for a load, else 0.
- HALT: absorbing until rst. All strobes 0.
- Latency (no stalls): REG/IMM 4 cycles, load 5, store 4, branch 3, squashed 2.
- Simultaneous events: dmem_ready on the same cycle the counter reaches MEM_TIMEOUT counts as success, with no fault.
- Field inputs are sampled as held by the IR; they are don't-care in FETCH.

Test Plan:
- Reset then ADD REG (tipo=00, opcode=000, cond=00, imem_valid=1): IRWrite at cycle 0, RegWrite+PCWrite at cycle 3; flags_q = alu_flags (e.g. 0100) after EXEC.
- MOV with shift (opcode=111, flag_mov_shift=10, tipo=01): ALUControl=110, ALUSrc=1, ImmSrc=01 in EXEC.
- Conditional squash: flags_q Z=0, cond=01, branch instruction → DECODE gives PCWrite=1, Branch=0, back to FETCH; flags_q unchanged.
- Load with 3-cycle dmem stall: MemRead high for 4 cycles; WB gives ResultSrc=1, RegWrite=1; total 8 cycles.
- Store timeout (MEM_TIMEOUT=15, dmem_ready=0 forever): MemWrite drops after 15 cycles; fault=1, state_q=5; rst asserted asynchronously clears to FETCH, fault=0.
- Store with dmem_ready exactly on the timeout cycle: no fault, PCWrite=1, returns to FETCH.
